// File: rtl/alu_issue_queue.sv
// alu_issue_queue: request FIFO in front of the ALU, plus the issue controller.
// Requests are popped one at a time, driven to the ALU on registered operands,
// and each tagged result (or timeout) is held on a valid/ready output port
// together with the measured ALU latency.
module alu_issue_queue #(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_opcode,
   input  logic [15:0]              in_a,
   input  logic [15:0]              in_b,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     alu_start,
   output logic [3:0]               alu_opcode,
   output logic [15:0]              alu_a,
   output logic [15:0]              alu_b,
   input  logic                     alu_busy,
   input  logic                     alu_done,
   input  logic [31:0]              alu_result,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_result,
   output logic [TAG_W-1:0]         out_tag,
   output logic [7:0]               out_cycles,
   output logic                     out_timeout,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [3:0]       opcode;
      logic [15:0]      a;
      logic [15:0]      b;
      logic [TAG_W-1:0] tag;
   } req_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   req_t             mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   state_t           state;
   state_t           state_next;
   logic [7:0]       cnt;
   logic [8:0]       cnt_inc;
   logic [TAG_W-1:0] tag_hold;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             timeout_hit;

   // Full/empty come from registered count only: no write-through on a full FIFO.
   always_comb begin
      full        = (count == (AW+1)'(DEPTH));
      empty       = (count == '0);
      in_ready    = !full;
      push        = in_valid && !full;
      pop         = (state == IDLE) && !empty && !out_valid && !alu_busy;
      cnt_inc     = {1'b0, cnt} + 9'd1;
      timeout_hit = (cnt_inc == 9'(TIMEOUT));
      alu_start   = (state == ISSUE);
      occupancy   = count;
   end

   // Request storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{opcode: in_opcode, a: in_a, b: in_b, tag: in_tag};
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Issue FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Issue FSM next state: a done pulse in WAIT wins over a coincident timeout.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pop) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (alu_done || timeout_hit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand/tag capture on pop, latency counter, and the result holding register.
   // Operands only move on a pop, so they stay stable through the done cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_opcode  <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         tag_hold    <= '0;
         cnt         <= '0;
         out_valid   <= 1'b0;
         out_result  <= '0;
         out_tag     <= '0;
         out_cycles  <= '0;
         out_timeout <= 1'b0;
      end else begin
         if (pop) begin
            alu_opcode <= mem[rd_ptr].opcode;
            alu_a      <= mem[rd_ptr].a;
            alu_b      <= mem[rd_ptr].b;
            tag_hold   <= mem[rd_ptr].tag;
         end
         if (state == ISSUE) cnt <= '0;
         else if (state == WAIT) cnt <= cnt_inc[7:0];
         if (out_valid && out_ready) out_valid <= 1'b0;
         // Issue is blocked while out_valid is high, so completion never clobbers a result.
         if (state == WAIT && (alu_done || timeout_hit)) begin
            out_valid   <= 1'b1;
            out_tag     <= tag_hold;
            out_cycles  <= cnt_inc[8] ? 8'hFF : cnt_inc[7:0];
            out_timeout <= !alu_done;
            out_result  <= alu_done ? alu_result : 32'd0;
         end
      end
   end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Request buffer and issue controller that sits directly upstream of the base-10 ALU. It accepts operation requests (opcode, a, b, tag) on a valid/ready port into a small FIFO and issues them one at a time over the ALU start/busy/done handshake. It holds the ALU operands stable for the whole operation and returns each tagged result, with its measured ALU latency in cycles, on a valid/ready output port.

## Interface
- DEPTH, 4: request FIFO entries; power of two, at least 2.
- TAG_W, 4: request tag width.
- TIMEOUT, 64: maximum cycles in WAIT before the operation is abandoned; range 2..255.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid / in_ready  in / out  1 / 1  request handshake.
- in_opcode, in_a, in_b, in_tag  in  4, 16, 16, TAG_W  request fields.
- alu_start  out  1  one-cycle start pulse to the ALU.
- alu_opcode, alu_a, alu_b  out  4, 16, 16  ALU operands; registered.
- alu_busy, alu_done  in  1, 1  ALU status; done is a one-cycle pulse.
- alu_result  in  32  ALU result; valid only in the alu_done cycle.
- out_valid / out_ready  out / in  1 / 1  result handshake.
- out_result, out_tag  out  32, TAG_W  completed result and its request tag.
- out_cycles  out  8  cycles from the alu_start cycle to the alu_done cycle.
- out_timeout  out  1  result was abandoned; out_result is 0.
- occupancy  out  $clog2(DEPTH)+1  number of FIFO entries.

## Operation
- FIFO:
  - Write when in_valid && in_ready.
  - in_ready = !full. full is computed from registered state, so there is no write-through when full, even if a pop happens in the same cycle.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE -> ISSUE when the FIFO is non-empty && !out_valid && !alu_busy. In that cycle, pop the head into alu_opcode/alu_a/alu_b and a held tag register.
  - ISSUE: alu_start = 1 for exactly this cycle; clear the cycle counter. Go to WAIT.
  - WAIT: the counter increments each cycle.
    - On alu_done: out_result <= alu_result, out_cycles <= counter+1 (saturating at 255), out_timeout <= 0, out_valid <= 1. Go to IDLE.
    - If counter+1 reaches TIMEOUT without alu_done: out_result <= 0, out_timeout <= 1, out_valid <= 1. Go to IDLE.
- Operand stability: alu_opcode/alu_a/alu_b change only on a pop. They are therefore stable from ISSUE through the alu_done cycle. This is mandatory because the ALU evaluates its operands combinationally at completion.
- Output register:
  - Clears (out_valid <= 0) on out_valid && out_ready.
  - Issue is blocked while out_valid = 1, so a completion never overwrites an unread result.
- Opcodes are passed through unchecked. Undefined opcodes 9..15 return the ALU's result (0).
- An alu_done seen outside WAIT is ignored. This covers a late done arriving after a timeout.

## Timing
- Reset values: in_ready = 1, alu_start = 0, alu_opcode/a/b = 0, out_valid = 0, out_result = 0, out_tag = 0, out_cycles = 0, out_timeout = 0, occupancy = 0. FSM = IDLE, pointers = 0.
- Reset mid-operation discards all queued and in-flight requests. The ALU shares rst.
- Timeline for a request accepted in cycle t into an empty FIFO, with output free and ALU idle:
  - Pop in t+1.
  - alu_start in t+2 (= s).
  - For ALU latency L: alu_done in s+L+1, out_valid from s+L+2, out_cycles = L+1.
- Back-to-back requests: next alu_start no earlier than 2 cycles after out_valid && out_ready.
- occupancy updates the cycle after the push or pop.

## Test plan
- Single op: DEC_ADD a=1234, b=4321, tag=3, ALU LAT_DEC=1. Expect alu_start 2 cycles after accept; out_result=5555, out_tag=3, out_cycles=2.
- Latency mix: queue BIN_MUL 300×200, then DUO_MUL3 a=7 (LAT 6). Expect results 60000 then 21, both with out_cycles=7, delivered in order. Check alu_a is stable through each done.
- Full FIFO: push 5 requests with out_ready=0. Expect in_ready=0 after 4 entries, occupancy=4, only 1 issued; drain yields all tags in order.
- Backpressure: hold out_ready=0 for 20 cycles after the first result. Expect no second alu_start and out_result held. Release: second result follows.
- Timeout: TIMEOUT=8, stub ALU never asserts done. Expect out_valid with out_timeout=1, out_result=0 at 8 cycles after start. A late done is ignored.
- Reset during WAIT: assert rst. Expect all outputs at reset values next cycle, occupancy=0, in_ready=1, and no spurious out_valid afterwards.
